dht11_sched: RTL
================

DHT11_SCHED -- requirements
Module: dht11_sched

Interface
REQ-001 Parameter T_GAP, default 2000000, minimum µs between consecutive meas_start pulses (sensor settle/refresh).
REQ-002 Parameter T_WDOG, default 30000, µs allowed from meas_start to meas_done/meas_err before declaring timeout.
REQ-003 Parameter MAX_TRY, default 3, total attempts per transaction including the first.
REQ-004 Parameter POLL_GAPS, default 5, autopoll period in units of T_GAP (used only with autopoll).
REQ-005 clk_1us  input  1  1 MHz block clock; all logic on its rising edge.
REQ-006 sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-007 req  input  2  one-cycle read request pulse per requester (bit0 UART command path, bit1 display path).
REQ-008 ack  output  2  one-cycle completion pulse per requester; rsp_* valid in the same cycle.
REQ-009 rsp_err  output  1  transaction failed after MAX_TRY attempts.
REQ-010 rsp_data  output  32  {hum_int, hum_dec, tmp_int, tmp_dec} of the last checksum-good reading.
REQ-011 cache_valid  output  1  at least one good reading captured since reset.
REQ-012 busy  output  1  high in any state except IDLE.
REQ-013 meas_start  output  1  one-cycle pulse launching one sensor transaction on the bus controller.
REQ-014 meas_done  input  1  one-cycle pulse: meas_data holds 40 received bits.
REQ-015 meas_err  input  1  one-cycle pulse: bus controller saw no sensor response.
REQ-016 meas_data  input  40  {hum_int, hum_dec, tmp_int, tmp_dec, checksum}, MSB first.

Function
REQ-017 pend[1:0] set by req[i]; cleared by ack[i]; set wins when req[i] and ack[i] coincide.
REQ-018 gap_cnt cleared on each meas_start, increments per cycle, saturates at T_GAP; gap_ok = (gap_cnt == T_GAP).
REQ-019 States: IDLE, START, WAIT, HOLD, RESP.
REQ-020 IDLE -> START when (pend != 0) and gap_ok; waits in IDLE otherwise.
REQ-021 START (1 cycle): meas_start=1; served <= pend; try_cnt <= 1 on first attempt; wd_cnt <= 0; -> WAIT.
REQ-022 Requests arriving after START stay pending for the next transaction (no join in flight).
REQ-023 WAIT: wd_cnt increments; good = meas_done and checksum == (sum of the 4 data bytes) mod 256.
REQ-024 WAIT -> RESP with rsp_err=0 on good; rsp_data and cache updated the same edge; cache_valid <= 1.
REQ-025 WAIT fail = meas_err, meas_done with bad checksum, or wd_cnt == T_WDOG-1 with no pulse.
REQ-026 meas_err and meas_done together count as fail; meas_done on the watchdog-expiry cycle counts as done.
REQ-027 On fail: try_cnt < MAX_TRY -> HOLD; else -> RESP with rsp_err=1 and rsp_data unchanged.
REQ-028 HOLD: wait for gap_ok; then -> START with try_cnt+1 and served unchanged.
REQ-029 RESP (1 cycle): ack = served; served <= 0; -> IDLE; rsp_err holds its value until the next RESP.
REQ-030 Pulses on meas_done/meas_err outside WAIT are ignored.

Reset
REQ-031 Asserting sys_rst_n low, at any time, forces IDLE, pend=0, served=0, try_cnt=0, wd_cnt=0, gap_cnt=0.
REQ-032 At reset: ack=0, meas_start=0, rsp_err=0, rsp_data=0, cache_valid=0, busy=0.
REQ-033 With gap_cnt=0 after reset, the first meas_start is no earlier than T_GAP cycles after deassertion (power-up settle).

Configuration
REQ-034 Macro DHT11_SCHED_AUTOPOLL_EN defined: internal requester pend[2] set every POLL_GAPS*T_GAP cycles; it joins served like pend[1:0] but produces no ack and only refreshes the cache.
REQ-035 Macro undefined: no internal requester or poll counter; transactions start only from req.

Verification
REQ-036 T_GAP=100; req=01 at cycle 5; meas_done with valid checksum 10 cycles after meas_start -> meas_start at cycle 100, ack=01, rsp_err=0, cache_valid=1.
REQ-037 req[0] and req[1] in the same cycle -> exactly one meas_start; ack=11 in a single cycle.
REQ-038 Checksum off by 1 three times, MAX_TRY=3 -> 3 meas_start pulses spaced >= T_GAP apart; ack with rsp_err=1; rsp_data holds the previous good value.
REQ-039 No response, T_WDOG=50 -> fail after 50 cycles in WAIT; second attempt good -> rsp_err=0.
REQ-040 sys_rst_n low during WAIT -> all outputs zero next cycle; late meas_done ignored; no ack emitted.
REQ-041 DHT11_SCHED_AUTOPOLL_EN, POLL_GAPS=2, T_GAP=100, no req -> meas_start every 200 cycles, ack stays 0, cache updates.

Source files
------------

// File: rtl/dht11_sched.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : dht11_sched                                                      |
// | Purpose  : Arbitrates DHT11 read requests from two requesters, paces sensor |
// |            transactions at least T_GAP us apart, retries failed readings up |
// |            to MAX_TRY attempts and serves the last checksum-good reading.   |
// | Ports    : clk_1us      - 1 MHz clock, rising edge                          |
// |            sys_rst_n    - asynchronous active-low reset                     |
// |            req[1:0]     - request pulses (bit0 UART path, bit1 display)     |
// |            ack[1:0]     - completion pulses, rsp_* valid in same cycle      |
// |            rsp_err      - last transaction failed after all attempts        |
// |            rsp_data     - {hum_int, hum_dec, tmp_int, tmp_dec}              |
// |            cache_valid  - a good reading has been captured since reset      |
// |            busy         - scheduler is not idle                             |
// |            meas_start   - launches one bus-controller transaction           |
// |            meas_done    - bus controller returned 40 bits in meas_data      |
// |            meas_err     - bus controller saw no sensor response             |
// |            meas_data    - {hum_int, hum_dec, tmp_int, tmp_dec, checksum}    |
// | Options  : DHT11_SCHED_AUTOPOLL_EN - adds an internal requester that        |
// |            refreshes the cache every POLL_GAPS*T_GAP cycles (no ack).       |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
module dht11_sched #(
   parameter int unsigned T_GAP     = 2000000,
   parameter int unsigned T_WDOG    = 30000,
   parameter int unsigned MAX_TRY   = 3,
   parameter int unsigned POLL_GAPS = 5
) (
   input  logic        clk_1us,
   input  logic        sys_rst_n,
   input  logic [1:0]  req,
   output logic [1:0]  ack,
   output logic        rsp_err,
   output logic [31:0] rsp_data,
   output logic        cache_valid,
   output logic        busy,
   output logic        meas_start,
   input  logic        meas_done,
   input  logic        meas_err,
   input  logic [39:0] meas_data
);

   if (T_GAP < 1 || T_WDOG < 2 || MAX_TRY < 1 || POLL_GAPS < 1) begin : g_param_check
      $error("dht11_sched: T_GAP, MAX_TRY and POLL_GAPS must be >= 1, T_WDOG >= 2");
   end

`ifdef DHT11_SCHED_AUTOPOLL_EN
   // pend[2] is the internal autopoll requester
   localparam int unsigned c_NREQ = 3;
`else
   localparam int unsigned c_NREQ = 2;
`endif

   localparam int unsigned c_GAP_W = $clog2(T_GAP + 1);
   localparam int unsigned c_WD_W  = $clog2(T_WDOG + 1);
   localparam int unsigned c_TRY_W = $clog2(MAX_TRY + 1);

   localparam logic [c_GAP_W-1:0] c_GAP_MAX = c_GAP_W'(T_GAP);
   localparam logic [c_WD_W-1:0]  c_WD_LAST = c_WD_W'(T_WDOG - 1);
   localparam logic [c_TRY_W-1:0] c_MAX_TRY = c_TRY_W'(MAX_TRY);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_WAIT  = 3'd2,
      S_HOLD  = 3'd3,
      S_RESP  = 3'd4
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [c_NREQ-1:0]   r_pend;
   logic [c_NREQ-1:0]   r_served;
   logic [c_NREQ-1:0]   w_pend_set;
   logic [c_NREQ-1:0]   w_pend_clr;
   logic [c_TRY_W-1:0]  r_try_cnt;
   logic [c_WD_W-1:0]   r_wd_cnt;
   logic [c_GAP_W-1:0]  r_gap_cnt;
   logic                w_gap_ok;
   logic [7:0]          w_sum;
   logic                w_good;
   logic                w_fail;
   logic                w_retry;

`ifdef DHT11_SCHED_AUTOPOLL_EN
   localparam int unsigned c_POLL_PERIOD = POLL_GAPS * T_GAP;
   localparam int unsigned c_POLL_W      = $clog2(c_POLL_PERIOD + 1);
   localparam logic [c_POLL_W-1:0] c_POLL_LAST = c_POLL_W'(c_POLL_PERIOD - 1);

   logic [c_POLL_W-1:0] r_poll_cnt;
   logic                w_poll_tick;

   assign w_poll_tick = (r_poll_cnt == c_POLL_LAST);

   always_ff @(posedge clk_1us or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_poll_cnt <= '0;
      end else if (w_poll_tick) begin
         r_poll_cnt <= '0;
      end else begin
         r_poll_cnt <= r_poll_cnt + 1'b1;
      end
   end

   assign w_pend_set = {w_poll_tick, req};
`else
   assign w_pend_set = req;
`endif

   // Checksum is the modulo-256 sum of the four data bytes
   assign w_sum    = meas_data[39:32] + meas_data[31:24] + meas_data[23:16] + meas_data[15:8];
   assign w_good   = meas_done && !meas_err && (w_sum == meas_data[7:0]);
   // Only consulted when w_good is low; a done pulse on the expiry cycle
   // therefore still wins over the watchdog if its checksum is good.
   assign w_fail   = meas_err || meas_done || (r_wd_cnt == c_WD_LAST);
   assign w_retry  = (r_try_cnt < c_MAX_TRY);
   assign w_gap_ok = (r_gap_cnt == c_GAP_MAX);

   // Pending bits are released only in RESP; clearing the full served mask
   // also retires the autopoll requester, which never reaches ack.
   assign w_pend_clr = (r_state == S_RESP) ? r_served : '0;

   always_ff @(posedge clk_1us or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      meas_start  = 1'b0;
      ack         = 2'b00;
      busy        = (r_state != S_IDLE);
      case (r_state)
         S_IDLE: begin
            if ((|r_pend) && w_gap_ok) begin
               w_state_nxt = S_START;
            end
         end
         S_START: begin
            meas_start  = 1'b1;
            w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (w_good) begin
               w_state_nxt = S_RESP;
            end else if (w_fail) begin
               w_state_nxt = w_retry ? S_HOLD : S_RESP;
            end
         end
         S_HOLD: begin
            if (w_gap_ok) begin
               w_state_nxt = S_START;
            end
         end
         S_RESP: begin
            ack         = r_served[1:0];
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_1us or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_pend      <= '0;
         r_served    <= '0;
         r_try_cnt   <= '0;
         r_wd_cnt    <= '0;
         r_gap_cnt   <= '0;
         rsp_err     <= 1'b0;
         rsp_data    <= '0;
         cache_valid <= 1'b0;
      end else begin
         // A request coinciding with its own ack stays pending
         r_pend <= (r_pend & ~w_pend_clr) | w_pend_set;

         if (r_state == S_START) begin
            r_gap_cnt <= '0;
         end else if (!w_gap_ok) begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
         end

         case (r_state)
            S_START: begin
               // try_cnt is zero only on the first attempt of a transaction;
               // retries keep the original served set.
               if (r_try_cnt == '0) begin
                  r_served <= r_pend;
               end
               r_try_cnt <= r_try_cnt + 1'b1;
               r_wd_cnt  <= '0;
            end
            S_WAIT: begin
               r_wd_cnt <= r_wd_cnt + 1'b1;
               if (w_good) begin
                  rsp_err     <= 1'b0;
                  rsp_data    <= meas_data[39:8];
                  cache_valid <= 1'b1;
               end else if (w_fail && !w_retry) begin
                  rsp_err <= 1'b1;
               end
            end
            S_RESP: begin
               r_served  <= '0;
               r_try_cnt <= '0;
            end
            default: begin
            end
         endcase
      end
   end

endmodule
`default_nettype wire
